counter_sequencer: RTL and testbench

Control FSM that sequences an external WIDTH-bit up-counter. The counter has a synchronous active-high reset, an enable input and a sticky overflow flag. The sequencer accepts a start request carrying a period and a repeat count, then clears and enables the counter to produce a programmed number of equal intervals. It signals a tick per interval and done at the end, and reports faults. It sits between a host/CSR requester and the counter datapath, and is the only driver of the counter's reset and enable.

---
 rtl/counter_sequencer.sv | 118 +++++++++++
 tb/tb_counter_sequencer.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/counter_sequencer.sv
// Sequencer that clears/enables an external up-counter for (reps+1) intervals of period+2 cycles.
// Optional COUNTER_SEQ_OVF_CHECK_EN: treat counter overflow before the terminal value as a fault.
module counter_sequencer #(
   parameter int WIDTH  = 4,
   parameter int REPS_W = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start_req,
   input  logic [WIDTH-1:0]  period,
   input  logic [REPS_W-1:0] reps,
   input  logic              abort,
   input  logic [WIDTH-1:0]  cnt_value,
   input  logic              cnt_ovf,
   output logic              cnt_rst,
   output logic              cnt_en,
   output logic              start_ack,
   output logic              busy,
   output logic              tick,
   output logic              done,
   output logic              err
);

   typedef enum logic [1:0] {IDLE, CLEAR, RUN, DONE} state_t;

   state_t            state, state_nxt;
   logic [WIDTH-1:0]  period_q;
   logic [REPS_W-1:0] reps_q, rep_cnt;

   logic match, last, ovf_fault;
   logic accept, reject, tick_set, rep_inc, fault_set;

   assign match = (cnt_value == period_q);
   assign last  = (rep_cnt == reps_q);
   assign busy  = (state != IDLE);

`ifdef COUNTER_SEQ_OVF_CHECK_EN
   assign ovf_fault = cnt_ovf && !match;
`else
   logic ovf_unused;
   assign ovf_unused = cnt_ovf;
   assign ovf_fault  = 1'b0;
`endif

   always_comb begin
      state_nxt = state;
      cnt_rst   = 1'b1;
      cnt_en    = 1'b0;
      done      = 1'b0;
      accept    = 1'b0;
      reject    = 1'b0;
      tick_set  = 1'b0;
      rep_inc   = 1'b0;
      fault_set = 1'b0;
      case (state)
         IDLE: begin
            if (start_req) begin
               if (period != '0) begin
                  accept    = 1'b1;
                  state_nxt = CLEAR;
               end else begin
                  reject = 1'b1;
               end
            end
         end
         CLEAR: state_nxt = abort ? IDLE : RUN;
         RUN: begin
            cnt_rst = 1'b0;
            // abort also freezes the counter in the cycle it is seen
            cnt_en  = !match && !abort;
            if (abort) begin
               state_nxt = IDLE;
            end else if (ovf_fault) begin
               fault_set = 1'b1;
               state_nxt = IDLE;
            end else if (match) begin
               tick_set = 1'b1;
               if (last) begin
                  state_nxt = DONE;
               end else begin
                  rep_inc   = 1'b1;
                  state_nxt = CLEAR;
               end
            end
         end
         DONE: begin
            done      = 1'b1;
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= IDLE;
         period_q  <= '0;
         reps_q    <= '0;
         rep_cnt   <= '0;
         start_ack <= 1'b0;
         tick      <= 1'b0;
         err       <= 1'b0;
      end else begin
         state     <= state_nxt;
         start_ack <= accept || reject;
         tick      <= tick_set;
         err       <= reject || fault_set;
         if (accept) begin
            period_q <= period;
            reps_q   <= reps;
            rep_cnt  <= '0;
         end else if (rep_inc) begin
            rep_cnt  <= rep_cnt + 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_counter_sequencer.sv
// Directed bench for counter_sequencer with a behavioural model of the external counter.
module tb_counter_sequencer;

   logic       clk = 1'b0;
   logic       reset, start_req, abort, force_ovf;
   logic [3:0] period, reps;
   logic [3:0] cnt_q;
   logic       ovf_q;
   logic       cnt_ovf;
   logic       cnt_rst, cnt_en, start_ack, busy, tick, done, err;
   logic [6:0] ov;

   int n_chk = 0, n_pass = 0;
   int rel, done_at, err_n, busy_n, ack_n, ack_at;
   int tick_q[$];

   assign cnt_ovf = ovf_q | force_ovf;
   assign ov      = {cnt_rst, cnt_en, start_ack, busy, tick, done, err};

   counter_sequencer #(.WIDTH(4), .REPS_W(4)) dut (
      .clk(clk), .reset(reset), .start_req(start_req), .period(period), .reps(reps),
      .abort(abort), .cnt_value(cnt_q), .cnt_ovf(cnt_ovf), .cnt_rst(cnt_rst),
      .cnt_en(cnt_en), .start_ack(start_ack), .busy(busy), .tick(tick),
      .done(done), .err(err)
   );

   always #5 clk = ~clk;

   // external counter: sync reset, enable, sticky flag set once all-ones is reached
   always @(posedge clk) begin
      if (cnt_rst) begin
         cnt_q <= '0;
         ovf_q <= 1'b0;
      end else begin
         if (cnt_en) cnt_q <= cnt_q + 4'd1;
         if (cnt_q == 4'hF) ovf_q <= 1'b1;
      end
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
      rel++;
      if (tick)      tick_q.push_back(rel);
      if (done)      done_at = rel;
      if (err)       err_n++;
      if (busy)      busy_n++;
      if (start_ack) begin ack_n++; ack_at = rel; end
   endtask

   task automatic clr_rec();
      rel = 0; done_at = -1; err_n = 0; busy_n = 0; ack_n = 0; ack_at = -1;
      tick_q.delete();
   endtask

   task automatic launch(input logic [3:0] p, input logic [3:0] r);
      clr_rec();
      period    = p;
      reps      = r;
      start_req = 1'b1;
      step();
      start_req = 1'b0;
   endtask

   function automatic int tick_at(input int k);
      return (tick_q.size() > k) ? tick_q[k] : -1;
   endfunction

   logic [6:0] s1_exp [1:7];

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      s1_exp = '{7'b1011000, 7'b0101000, 7'b0101000, 7'b0101000,
                 7'b0001000, 7'b1001110, 7'b1000000};
      reset = 1'b1; start_req = 1'b0; abort = 1'b0; force_ovf = 1'b0;
      period = '0; reps = '0;
      clr_rec();

      // reset then idle
      repeat (3) @(posedge clk);
      #1 chk("rst_outs", ov, 7'b1000000);
      reset = 1'b0;
      step();
      chk("idle_outs", ov, 7'b1000000);

      // abort in IDLE has no effect
      abort = 1'b1;
      step();
      chk("idle_abort", ov, 7'b1000000);
      abort = 1'b0;

      // single interval, cycle by cycle
      clr_rec();
      period = 4'd3; reps = 4'd0; start_req = 1'b1;
      #1 chk("s1_c0", ov, 7'b1000000);
      step();
      start_req = 1'b0;
      for (int i = 1; i <= 7; i++) begin
         if (i > 1) step();
         chk($sformatf("s1_c%0d", i), ov, s1_exp[i]);
         if (i >= 2 && i <= 5) chk($sformatf("s1_cnt%0d", i), cnt_q, i - 2);
      end
      run3: repeat (3) step();
      chk("s1_busy", busy_n, 6);
      chk("s1_ticks", tick_q.size(), 1);
      chk("s1_done", done_at, 6);

      // repeat: period=2, reps=2
      launch(4'd2, 4'd2);
      repeat (15) step();
      chk("rep_ticks", tick_q.size(), 3);
      chk("rep_t0", tick_at(0), 5);
      chk("rep_t1", tick_at(1), 9);
      chk("rep_t2", tick_at(2), 13);
      chk("rep_done", done_at, 13);
      chk("rep_busy", busy_n, 13);
      chk("rep_ack", ack_n, 1);
      chk("rep_err", err_n, 0);

      // max period: counter hits all-ones in the match cycle, not a fault
      launch(4'd15, 4'd1);
      repeat (37) step();
      chk("max_t0", tick_at(0), 18);
      chk("max_t1", tick_at(1), 35);
      chk("max_done", done_at, 35);
      chk("max_busy", busy_n, 35);
      chk("max_err", err_n, 0);

      // max reps: 16 intervals of 3 cycles
      launch(4'd1, 4'd15);
      repeat (52) step();
      chk("mreps_ticks", tick_q.size(), 16);
      chk("mreps_last", tick_at(15), 49);
      chk("mreps_done", done_at, 49);
      chk("mreps_busy", busy_n, 49);

      // reject period==0
      launch(4'd0, 4'd3);
      chk("rej_outs", ov, 7'b1010001);
      step();
      chk("rej_after", ov, 7'b1000000);
      chk("rej_busy", busy_n, 0);

      // abort in RUN at cnt_value=1
      launch(4'd5, 4'd0);
      step(); step();
      chk("abt_cnt", cnt_q, 1);
      abort = 1'b1;
      #1 chk("abt_en", cnt_en, 1'b0);
      step();
      abort = 1'b0;
      chk("abt_outs", ov, 7'b1000000);
      repeat (10) step();
      chk("abt_ticks", tick_q.size(), 0);
      chk("abt_done", done_at, -1);

      // asynchronous reset mid-sequence
      launch(4'd4, 4'd0);
      step(); step();
      #3 reset = 1'b1;
      #1 chk("arst_outs", ov, 7'b1000000);
      reset = 1'b0;
      step();
      chk("arst_idle", ov, 7'b1000000);

      // overflow while counting
      launch(4'd5, 4'd0);
      step(); step(); step();
      chk("ovf_cnt", cnt_q, 2);
      force_ovf = 1'b1;
      step();
      force_ovf = 1'b0;
`ifdef COUNTER_SEQ_OVF_CHECK_EN
      chk("ovf_busy", busy, 1'b0);
      chk("ovf_err", err, 1'b1);
      repeat (10) step();
      chk("ovf_done", done_at, -1);
      chk("ovf_errn", err_n, 1);
`else
      repeat (10) step();
      chk("ovf_done", done_at, 8);
      chk("ovf_tick", tick_at(0), 8);
      chk("ovf_errn", err_n, 0);
`endif

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
